// File: rtl/lsh_pkg.sv
// Shared types and helpers for the LSH window-vote path.
//   COUNT_W                   : width of one vote count
//   MAX_WINDOWS_IN_REFERENCE  : default number of reference windows
//   WINDOW_ID_W               : default window-ID width
//   count_vec_t               : array type of the count_bus vector
//   window_id_t               : one incoming window ID
//   state_e                   : query controller states
//   sat_inc32()               : increment that sticks at all-ones
package lsh_pkg;

    localparam int COUNT_W                  = 32;
    localparam int MAX_WINDOWS_IN_REFERENCE = 512;
    localparam int BUCKET_SIZE              = 16;
    localparam int WINDOW_ID_W              = 16;

    typedef logic [COUNT_W-1:0]     count_t;
    typedef count_t                 count_vec_t [MAX_WINDOWS_IN_REFERENCE];
    typedef logic [WINDOW_ID_W-1:0] window_id_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OPEN  = 2'd1,
        SCAN  = 2'd2,
        CLOSE = 2'd3
    } state_e;

    function automatic logic [COUNT_W-1:0] sat_inc32(input logic [COUNT_W-1:0] v);
        return (v == {COUNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/vote_count_bank.sv
// Bank of per-window vote counters.
//   clk, reset_vote_n : clock, synchronous active-low reset
//   clear             : zero every counter at the next edge
//   inc_en, inc_idx   : add one (saturating) to counter inc_idx
//   count_bus         : registered counter values
// clear has priority over inc_en; the controller never asserts both.
module vote_count_bank
    import lsh_pkg::*;
#(
    parameter int N_WIN = MAX_WINDOWS_IN_REFERENCE,
    parameter int IDX_W = $clog2(N_WIN)
) (
    input  logic               clk,
    input  logic               reset_vote_n,
    input  logic               clear,
    input  logic               inc_en,
    input  logic [IDX_W-1:0]   inc_idx,
    output logic [COUNT_W-1:0] count_bus [N_WIN]
);

    logic [COUNT_W-1:0] count_q [N_WIN];
    logic [COUNT_W-1:0] count_d [N_WIN];

    always_comb begin
        for (int i = 0; i < N_WIN; i++) begin
            count_d[i] = count_q[i];
        end
        if (clear) begin
            for (int i = 0; i < N_WIN; i++) begin
                count_d[i] = '0;
            end
        end else if (inc_en) begin
            count_d[inc_idx] = sat_inc32(count_q[inc_idx]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_vote_n) begin
            for (int i = 0; i < N_WIN; i++) begin
                count_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_WIN; i++) begin
                count_q[i] <= count_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_WIN; i++) begin
            count_bus[i] = count_q[i];
        end
    end

endmodule

// File: rtl/window_vote_counter.sv
// Query controller that turns LSH bucket lookups into per-window votes.
//   clk, reset_vote_n          : clock, synchronous active-low reset
//   query_start / query_end    : open a query (clearing counts) / close it
//   bucket_valid, bucket_ready : bucket handshake
//   bucket_ids, bucket_mask    : window IDs of a bucket and per-slot valid bits
//   is_query                   : high while a query is open
//   count_bus                  : per-window vote counts, held after close
//   query_done                 : one-cycle pulse in the first cycle is_query is 0
//   dropped_count              : out-of-range IDs this query (saturating)
//   protocol_error             : sticky misuse flag, cleared only by reset
//
// state | meaning
// IDLE  | no query; counts held for the consumer
// OPEN  | query open, waiting for a bucket or query_end
// SCAN  | walking the latched bucket, one slot per cycle
// CLOSE | is_query low, query_done pulse
module window_vote_counter
    import lsh_pkg::*;
#(
    parameter int MAX_WINDOWS_IN_REFERENCE = lsh_pkg::MAX_WINDOWS_IN_REFERENCE,
    parameter int BUCKET_SIZE              = lsh_pkg::BUCKET_SIZE,
    parameter int WINDOW_ID_W              = lsh_pkg::WINDOW_ID_W
) (
    input  logic                                   clk,
    input  logic                                   reset_vote_n,
    input  logic                                   query_start,
    input  logic                                   query_end,
    input  logic                                   bucket_valid,
    output logic                                   bucket_ready,
    input  logic [BUCKET_SIZE-1:0][WINDOW_ID_W-1:0] bucket_ids,
    input  logic [BUCKET_SIZE-1:0]                 bucket_mask,
    output logic                                   is_query,
    output logic [COUNT_W-1:0]                     count_bus [MAX_WINDOWS_IN_REFERENCE],
    output logic                                   query_done,
    output logic [15:0]                            dropped_count,
    output logic                                   protocol_error
);

    localparam int SLOT_W = $clog2(BUCKET_SIZE);
    localparam int WIN_W  = $clog2(MAX_WINDOWS_IN_REFERENCE);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(BUCKET_SIZE - 1);

    state_e                                  state_q, state_d;
    logic                                    pend_q, pend_d;
    logic [SLOT_W-1:0]                       idx_q, idx_d;
    logic [BUCKET_SIZE-1:0][WINDOW_ID_W-1:0] ids_q, ids_d;
    logic [BUCKET_SIZE-1:0]                  mask_q, mask_d;
    logic [15:0]                             dropped_q, dropped_d;
    logic                                    perr_q, perr_d;
    logic                                    is_query_q, is_query_d;
    logic                                    bucket_ready_q, bucket_ready_d;
    logic                                    query_done_q, query_done_d;

    logic                   accept;
    logic [WINDOW_ID_W-1:0] cur_id;
    logic                   in_range;
    logic                   bank_clear;
    logic                   bank_inc;

    always_comb begin
        accept   = (state_q == OPEN) && bucket_valid && bucket_ready_q;
        cur_id   = ids_q[idx_q];
        in_range = cur_id < WINDOW_ID_W'(MAX_WINDOWS_IN_REFERENCE);
    end

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        idx_d      = idx_q;
        ids_d      = ids_q;
        mask_d     = mask_q;
        dropped_d  = dropped_q;
        perr_d     = perr_q;
        bank_clear = 1'b0;
        bank_inc   = 1'b0;

        // A simultaneous start+end in IDLE is a legal empty query, not misuse.
        if (query_start && state_q != IDLE)                 perr_d = 1'b1;
        if (query_end && state_q == IDLE && !query_start)  perr_d = 1'b1;
        if (bucket_valid && state_q != OPEN)               perr_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (query_start) begin
                    bank_clear = 1'b1;
                    dropped_d  = '0;
                    pend_d     = query_end;
                    state_d    = OPEN;
                end
            end
            OPEN: begin
                if (accept) begin
                    ids_d   = bucket_ids;
                    mask_d  = bucket_mask;
                    idx_d   = '0;
                    pend_d  = pend_q | query_end;
                    state_d = SCAN;
                end else if (query_end || pend_q) begin
                    pend_d  = 1'b0;
                    state_d = CLOSE;
                end
            end
            SCAN: begin
                if (mask_q[idx_q]) begin
                    if (in_range) begin
                        bank_inc = 1'b1;
                    end else if (dropped_q != 16'hFFFF) begin
                        dropped_d = dropped_q + 16'd1;
                    end
                end
                if (idx_q == LAST_SLOT) begin
                    idx_d   = '0;
                    pend_d  = 1'b0;
                    state_d = (pend_q || query_end) ? CLOSE : OPEN;
                end else begin
                    idx_d  = idx_q + 1'b1;
                    pend_d = pend_q | query_end;
                end
            end
            CLOSE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered copies decoded from the next state.
        is_query_d     = (state_d == OPEN) || (state_d == SCAN);
        bucket_ready_d = (state_d == OPEN);
        query_done_d   = (state_d == CLOSE);
    end

    always_ff @(posedge clk) begin
        if (!reset_vote_n) begin
            state_q        <= IDLE;
            pend_q         <= 1'b0;
            idx_q          <= '0;
            ids_q          <= '0;
            mask_q         <= '0;
            dropped_q      <= '0;
            perr_q         <= 1'b0;
            is_query_q     <= 1'b0;
            bucket_ready_q <= 1'b0;
            query_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            pend_q         <= pend_d;
            idx_q          <= idx_d;
            ids_q          <= ids_d;
            mask_q         <= mask_d;
            dropped_q      <= dropped_d;
            perr_q         <= perr_d;
            is_query_q     <= is_query_d;
            bucket_ready_q <= bucket_ready_d;
            query_done_q   <= query_done_d;
        end
    end

    vote_count_bank #(
        .N_WIN (MAX_WINDOWS_IN_REFERENCE),
        .IDX_W (WIN_W)
    ) u_bank (
        .clk          (clk),
        .reset_vote_n (reset_vote_n),
        .clear        (bank_clear),
        .inc_en       (bank_inc),
        .inc_idx      (cur_id[WIN_W-1:0]),
        .count_bus    (count_bus)
    );

    assign is_query       = is_query_q;
    assign bucket_ready   = bucket_ready_q;
    assign query_done     = query_done_q;
    assign dropped_count  = dropped_q;
    assign protocol_error = perr_q;

endmodule

// File: tb/tb_window_vote_counter.sv
// Directed bench for window_vote_counter: basic vote, latency/ready,
// range drop, pending end, hold/reclear, empty query, reset mid-scan.
module tb_window_vote_counter;

    logic                clk;
    logic                reset_vote_n;
    logic                query_start;
    logic                query_end;
    logic                bucket_valid;
    logic                bucket_ready;
    logic [15:0][15:0]   bucket_ids;
    logic [15:0]         bucket_mask;
    logic                is_query;
    logic [31:0]         count_bus [512];
    logic                query_done;
    logic [15:0]         dropped_count;
    logic                protocol_error;

    int n_vec = 0;
    int n_err = 0;

    window_vote_counter dut (
        .clk            (clk),
        .reset_vote_n   (reset_vote_n),
        .query_start    (query_start),
        .query_end      (query_end),
        .bucket_valid   (bucket_valid),
        .bucket_ready   (bucket_ready),
        .bucket_ids     (bucket_ids),
        .bucket_mask    (bucket_mask),
        .is_query       (is_query),
        .count_bus      (count_bus),
        .query_done     (query_done),
        .dropped_count  (dropped_count),
        .protocol_error (protocol_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int nz_count();
        int n = 0;
        for (int i = 0; i < 512; i++) begin
            if (count_bus[i] != 32'd0) n++;
        end
        return n;
    endfunction

    initial begin
        int lows;
        int bad;
        int pulses;

        reset_vote_n = 1'b0;
        query_start  = 1'b0;
        query_end    = 1'b0;
        bucket_valid = 1'b0;
        bucket_ids   = '0;
        bucket_mask  = '0;
        tick();
        tick();

        // Reset state
        chk("rst_is_query", 32'(is_query), 32'd0);
        chk("rst_ready", 32'(bucket_ready), 32'd0);
        chk("rst_done", 32'(query_done), 32'd0);
        chk("rst_dropped", 32'(dropped_count), 32'd0);
        chk("rst_perr", 32'(protocol_error), 32'd0);
        chk("rst_nz", 32'(nz_count()), 32'd0);
        reset_vote_n = 1'b1;
        tick();

        // Basic vote: ids {3,3,7,100...}, mask 0007
        query_start = 1'b1;
        tick();
        query_start = 1'b0;
        chk("basic_open_isq", 32'(is_query), 32'd1);
        chk("basic_open_ready", 32'(bucket_ready), 32'd1);
        for (int i = 0; i < 16; i++) bucket_ids[i] = 16'd100;
        bucket_ids[0] = 16'd3;
        bucket_ids[1] = 16'd3;
        bucket_ids[2] = 16'd7;
        bucket_mask   = 16'h0007;
        bucket_valid  = 1'b1;
        tick();
        bucket_valid = 1'b0;
        lows = bucket_ready ? 0 : 1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i == 0) chk("basic_lat_slot0", count_bus[3], 32'd1);
            if (!bucket_ready) lows++;
        end
        chk("basic_ready_low_cycles", 32'(lows), 32'd16);
        chk("basic_ready_back", 32'(bucket_ready), 32'd1);
        chk("basic_cnt3", count_bus[3], 32'd2);
        chk("basic_cnt7", count_bus[7], 32'd1);
        chk("basic_cnt100", count_bus[100], 32'd0);
        chk("basic_nz", 32'(nz_count()), 32'd2);
        query_end = 1'b1;
        tick();
        query_end = 1'b0;
        chk("basic_close_isq", 32'(is_query), 32'd0);
        chk("basic_close_done", 32'(query_done), 32'd1);
        tick();
        chk("basic_idle_done", 32'(query_done), 32'd0);
        chk("basic_idle_cnt3", count_bus[3], 32'd2);
        chk("basic_perr", 32'(protocol_error), 32'd0);

        // Range drop: ids {600,511,512}
        query_start = 1'b1;
        tick();
        query_start = 1'b0;
        chk("drop_cleared_cnt3", count_bus[3], 32'd0);
        bucket_ids    = '0;
        bucket_ids[0] = 16'd600;
        bucket_ids[1] = 16'd511;
        bucket_ids[2] = 16'd512;
        bucket_mask   = 16'h0007;
        bucket_valid  = 1'b1;
        tick();
        bucket_valid = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        chk("drop_cnt511", count_bus[511], 32'd1);
        chk("drop_dropped", 32'(dropped_count), 32'd2);
        chk("drop_nz", 32'(nz_count()), 32'd1);
        query_end = 1'b1;
        tick();
        query_end = 1'b0;
        tick();

        // Pending end: query_end with the accept; ids {1,2,2,1}
        query_start = 1'b1;
        tick();
        query_start = 1'b0;
        chk("pend_dropped_cleared", 32'(dropped_count), 32'd0);
        bucket_ids    = '0;
        bucket_ids[0] = 16'd1;
        bucket_ids[1] = 16'd2;
        bucket_ids[2] = 16'd2;
        bucket_ids[3] = 16'd1;
        bucket_mask   = 16'h000F;
        bucket_valid  = 1'b1;
        query_end     = 1'b1;
        tick();
        bucket_valid = 1'b0;
        query_end    = 1'b0;
        lows = is_query ? 0 : 1;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (!is_query) lows++;
        end
        chk("pend_isq_held", 32'(lows), 32'd0);
        tick();
        chk("pend_close_isq", 32'(is_query), 32'd0);
        chk("pend_close_done", 32'(query_done), 32'd1);
        chk("pend_cnt1", count_bus[1], 32'd2);
        chk("pend_cnt2", count_bus[2], 32'd2);

        // Hold for 20 idle cycles
        bad = 0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (count_bus[1] != 32'd2 || count_bus[2] != 32'd2 || nz_count() != 2) bad++;
            if (query_done) pulses++;
        end
        chk("hold_stable", 32'(bad), 32'd0);
        chk("hold_no_done", 32'(pulses), 32'd0);
        chk("hold_isq", 32'(is_query), 32'd0);

        // Reclear and ignored query_start in OPEN
        query_start = 1'b1;
        tick();
        chk("reclear_nz", 32'(nz_count()), 32'd0);
        tick();
        query_start = 1'b0;
        chk("restart_perr", 32'(protocol_error), 32'd1);
        chk("restart_still_open", 32'(bucket_ready), 32'd1);

        // Latency with a second bucket held during SCAN
        bucket_ids    = '0;
        bucket_ids[0] = 16'd5;
        bucket_mask   = 16'h0001;
        bucket_valid  = 1'b1;
        tick();
        chk("lat_t0_cnt5", count_bus[5], 32'd0);
        bucket_ids[0] = 16'd6;
        tick();
        chk("lat_t1_cnt5", count_bus[5], 32'd1);
        for (int i = 0; i < 15; i++) tick();
        chk("lat_ready_t16", 32'(bucket_ready), 32'd1);
        chk("lat_cnt6_before", count_bus[6], 32'd0);
        tick();
        bucket_valid = 1'b0;
        chk("lat_second_accept", 32'(bucket_ready), 32'd0);
        tick();
        chk("lat_cnt6", count_bus[6], 32'd1);
        for (int i = 0; i < 15; i++) tick();
        chk("lat_ready_again", 32'(bucket_ready), 32'd1);

        // Reset during SCAN slot 5
        for (int i = 0; i < 16; i++) bucket_ids[i] = 16'd9;
        bucket_mask  = 16'hFFFF;
        bucket_valid = 1'b1;
        tick();
        bucket_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("rstscan_cnt9", count_bus[9], 32'd5);
        reset_vote_n = 1'b0;
        tick();
        reset_vote_n = 1'b1;
        chk("rstscan_isq", 32'(is_query), 32'd0);
        chk("rstscan_ready", 32'(bucket_ready), 32'd0);
        chk("rstscan_nz", 32'(nz_count()), 32'd0);
        chk("rstscan_perr", 32'(protocol_error), 32'd0);
        chk("rstscan_dropped", 32'(dropped_count), 32'd0);
        tick();
        chk("rstscan_stays_idle", 32'(is_query), 32'd0);

        // Simultaneous start+end: empty query, no error
        query_start = 1'b1;
        query_end   = 1'b1;
        tick();
        query_start = 1'b0;
        query_end   = 1'b0;
        chk("empty_open_isq", 32'(is_query), 32'd1);
        tick();
        chk("empty_close_isq", 32'(is_query), 32'd0);
        chk("empty_close_done", 32'(query_done), 32'd1);
        chk("empty_perr", 32'(protocol_error), 32'd0);
        tick();

        // Lone query_end in IDLE
        query_end = 1'b1;
        tick();
        query_end = 1'b0;
        chk("idle_end_perr", 32'(protocol_error), 32'd1);
        chk("idle_end_isq", 32'(is_query), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
